// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one operation
// in flight, result held on the owner's response channel until it is taken.
module alu_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [80:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [80:0] req1_data,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] alu_read_data_1,
    output logic [31:0] alu_read_data_2,
    output logic [4:0]  alu_shmat,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_functioncode,
    input  logic [31:0] alu_result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int CW = 2;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  shmat;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } alu_op_t;

    logic [1:0]    state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] cnt;
    alu_op_t       op_q;
    logic [1:0]    req_vld;
    logic [1:0]    grant;
    logic [1:0]    rsp_rdy;
    alu_op_t       req_op;

    assign req_vld = {req1_valid, req0_valid};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    // A tie goes to whichever requester did not win last time.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && rst_n) begin
            case (req_vld)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req_op     = grant[1] ? alu_op_t'(req1_data) : alu_op_t'(req0_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            op_q       <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_q       <= req_op;
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        cnt        <= CW'(ALU_LATENCY);
                        state      <= EXEC;
                    end
                end
                // Operands stay on the ALU for ALU_LATENCY+1 cycles; count reaches 0 on the last.
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_rdy[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) &&  owner;

    assign alu_read_data_1  = op_q.rd1;
    assign alu_read_data_2  = op_q.rd2;
    assign alu_shmat        = op_q.shmat;
    assign alu_opcode       = op_q.opcode;
    assign alu_functioncode = op_q.funct;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: pipelined ALU models of depth ALU_LATENCY,
// scoreboard queue of expected {owner, result}, second instance at ALU_LATENCY=3.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic r0v, r1v, s0r, s1r;
    logic [80:0] d0, d1;

    logic r0r, r1r, s0v, s1v;
    logic [31:0] rres, a1, a2, ares1;
    logic [4:0]  sh;
    logic [5:0]  op, fn;

    logic r0r_3, r1r_3, s0v_3, s1v_3;
    logic [31:0] rres_3, a1_3, a2_3, ares3;
    logic [4:0]  sh_3;
    logic [5:0]  op_3, fn_3;
    logic [31:0] p3 [3];

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int w, lat;
    logic [31:0] bp_exp, exp3;
    logic [80:0] saved;

    always #5 clk = ~clk;

    function automatic logic [80:0] mk(logic [31:0] a, logic [31:0] b, logic [4:0] s,
                                       logic [5:0] o, logic [5:0] f);
        return {a, b, s, o, f};
    endfunction

    function automatic logic [31:0] alu_f(logic [80:0] d);
        logic [31:0] a, b;
        logic [4:0]  s;
        a = d[80:49];
        b = d[48:17];
        s = d[16:12];
        if (d[11:6] != 6'd0) return a ^ b;
        case (d[5:0])
            6'b100000, 6'b100001: return a + b;
            6'b100010, 6'b100011: return a - b;
            6'b100100:            return a & b;
            6'b100101:            return a | b;
            6'b000000:            return b << s;
            default:              return a ^ b;
        endcase
    endfunction

    always @(posedge clk) begin
        ares1 <= alu_f({a1, a2, sh, op, fn});
        p3[0] <= alu_f({a1_3, a2_3, sh_3, op_3, fn_3});
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ares3 = p3[2];

    alu_arbiter #(.ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_data(d0),
        .req1_valid(r1v), .req1_ready(r1r), .req1_data(d1),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp1_valid(s1v), .rsp1_ready(s1r),
        .rsp_result(rres), .alu_read_data_1(a1), .alu_read_data_2(a2),
        .alu_shmat(sh), .alu_opcode(op), .alu_functioncode(fn), .alu_result(ares1)
    );

    alu_arbiter #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r_3), .req0_data(d0),
        .req1_valid(r1v), .req1_ready(r1r_3), .req1_data(d1),
        .rsp0_valid(s0v_3), .rsp0_ready(s0r), .rsp1_valid(s1v_3), .rsp1_ready(s1r),
        .rsp_result(rres_3), .alu_read_data_1(a1_3), .alu_read_data_2(a2_3),
        .alu_shmat(sh_3), .alu_opcode(op_3), .alu_functioncode(fn_3), .alu_result(ares3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait for a grant on the L=1 instance, check which requester got it, optionally score it.
    task automatic accept(input logic e0, input logic e1, input bit push, output int waited);
        waited = 0;
        #1;
        while (!(r0r | r1r) && waited < 20) begin
            tick();
            waited++;
        end
        chk("grant0", 32'(r0r), 32'(e0));
        chk("grant1", 32'(r1r), 32'(e1));
        if (push && (r0r | r1r)) sb.push_back('{owner: r1r, res: alu_f(r1r ? d1 : d0)});
    endtask

    task automatic wait_rsp(output int l);
        exp_t e;
        l = 0;
        while (!(s0v | s1v) && l < 20) begin
            tick();
            l++;
            if (!(s0v | s1v)) chk("busy_ready", 32'({r0r, r1r}), 32'(0));
        end
        chk("rsp_seen", 32'(s0v | s1v), 32'(1));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed response with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("rsp0_valid", 32'(s0v), 32'(!e.owner));
            chk("rsp1_valid", 32'(s1v), 32'(e.owner));
            chk("rsp_result", rres, e.res);
        end
    endtask

    initial begin
        r0v = 0; r1v = 0; s0r = 1; s1r = 1; d0 = '0; d1 = '0; rst_n = 0;
        repeat (2) @(posedge clk);
        tick();
        chk("rst_s0v", 32'(s0v), 0);
        chk("rst_s1v", 32'(s1v), 0);
        chk("rst_r0r", 32'(r0r), 0);
        chk("rst_r1r", 32'(r1r), 0);
        chk("rst_result", rres, 0);
        chk("rst_a1", a1, 0);
        chk("rst_a2", a2, 0);
        chk("rst_sh", 32'(sh), 0);
        chk("rst_op", 32'(op), 0);
        chk("rst_fn", 32'(fn), 0);
        chk("rst3_s0v", 32'(s0v_3), 0);
        chk("rst3_result", rres_3, 0);

        // Release with only requester 1 pending: granted in the very first cycle.
        rst_n = 1; r1v = 1; d1 = mk(32'd7, 32'd3, 5'd0, 6'd0, 6'b100010);
        accept(0, 1, 1, w);
        chk("release_wait", 32'(w), 0);
        wait_rsp(lat);
        r1v = 0;

        // Tie: both valid continuously, grants must alternate starting with requester 0.
        d0 = mk(32'h1111_0000, 32'h0000_2222, 5'd0, 6'd0, 6'b100000);
        d1 = mk(32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 6'd0, 6'b100100);
        r0v = 1; r1v = 1;
        for (int i = 0; i < 4; i++) begin
            accept(i % 2 == 0, i % 2 == 1, 1, w);
            wait_rsp(lat);
            if (i % 2 == 0) d0 = mk($urandom, $urandom, 5'(i + 3), 6'd0, 6'b000000);
            else            d1 = mk($urandom, $urandom, 5'd0, 6'd0, 6'b100010);
        end

        // Single addu on requester 0, latency T+3.
        r1v = 0;
        d0 = mk(32'h8000_0005, 32'h0000_000D, 5'd0, 6'd0, 6'b100000);
        accept(1, 0, 0, w);
        sb.push_back('{owner: 1'b0, res: 32'h8000_0012});
        wait_rsp(lat);
        chk("addu_latency", 32'(lat), 3);
        r0v = 0;
        tick();

        // Backpressure: owner holds off for 5 cycles, non-owner ready toggles.
        s0r = 0;
        d0 = mk(32'hF0F0_0000, 32'h0000_0FF0, 5'd0, 6'd0, 6'b100101);
        bp_exp = alu_f(d0);
        r0v = 1;
        accept(1, 0, 1, w);
        wait_rsp(lat);
        r1v = 1; d1 = mk(32'd100, 32'd1, 5'd0, 6'd0, 6'b100011);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_s0v", 32'(s0v), 1);
            chk("bp_s1v", 32'(s1v), 0);
            chk("bp_result", rres, bp_exp);
            chk("bp_readys", 32'({r0r, r1r}), 0);
            s1r = k[0];
        end
        s0r = 1; s1r = 1;
        tick();
        chk("bp_done_s0v", 32'(s0v), 0);
        accept(0, 1, 1, w);
        chk("bp_first_idle", 32'(w), 0);
        wait_rsp(lat);
        r0v = 0; r1v = 0;
        tick();

        // Reset in the middle of EXEC abandons the operation.
        d0 = mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd3, 6'd0, 6'b100101);
        r0v = 1;
        accept(1, 0, 0, w);
        tick();
        r0v = 0;
        chk("exec_a1", a1, 32'hA5A5_A5A5);
        rst_n = 0;
        tick();
        chk("abort_a1", a1, 0);
        chk("abort_a2", a2, 0);
        chk("abort_sh", 32'(sh), 0);
        chk("abort_fn", 32'(fn), 0);
        chk("abort_readys", 32'({r0r, r1r}), 0);
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_rsp", 32'({s0v, s1v, s0v_3, s1v_3}), 0);
        end

        // ALU_LATENCY=3 instance: operands stable T+1..T+4, response at T+5.
        d0 = mk(32'h0001_2345, 32'h0000_0F0F, 5'd4, 6'd0, 6'b100010);
        saved = d0;
        exp3 = alu_f(d0);
        r0v = 1;
        accept(1, 0, 0, w);
        chk("l3_ready", 32'(r0r_3), 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) begin
                chk("l3_a1", a1_3, saved[80:49]);
                chk("l3_a2", a2_3, saved[48:17]);
                chk("l3_fn", 32'(fn_3), 32'(saved[5:0]));
                chk("l3_not_yet", 32'(s0v_3), 0);
            end else begin
                chk("l3_s0v", 32'(s0v_3), 1);
                chk("l3_s1v", 32'(s1v_3), 0);
                chk("l3_result", rres_3, exp3);
            end
            if (k == 1) begin
                r0v = 0;
                d0 = mk(32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd1, 6'd0, 6'b100000);
            end
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LATENCY, default 1, meaning clock edges from ALU operand drive to a valid alu_result (legal 1..3).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 holds an operation.
REQ-005 The block SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 The block SHALL have port req0_data  input  81  {read_data_1[31:0], read_data_2[31:0], shmat[4:0], opcode[5:0], functioncode[5:0]}.
REQ-007 The block SHALL have ports req1_valid, req1_ready, req1_data with the same direction, width and meaning for requester 1.
REQ-008 The block SHALL have port rsp0_valid  output  1  result for requester 0 available.
REQ-009 The block SHALL have port rsp0_ready  input  1  requester 0 takes the result.
REQ-010 The block SHALL have ports rsp1_valid, rsp1_ready with the same meaning for requester 1.
REQ-011 The block SHALL have port rsp_result  output  32  captured ALU result, shared by both response channels.
REQ-012 The block SHALL have ports alu_read_data_1 (32), alu_read_data_2 (32), alu_shmat (5), alu_opcode (6), alu_functioncode (6), all outputs, driving the shared ALU.
REQ-013 The block SHALL have port alu_result  input  32  result from the shared ALU.

Function
REQ-014 The block SHALL implement states IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-015 In IDLE the block SHALL assert readyN combinationally only for the granted requester; both readys SHALL be 0 in EXEC and RESP.
REQ-016 Grant: one valid -> that requester; both valid -> the requester not recorded in last_grant; none -> no grant.
REQ-017 On acceptance (validN & readyN in IDLE) the block SHALL latch reqN_data, record owner N, set last_grant=N, go to EXEC.
REQ-018 In EXEC the block SHALL drive the alu_* ports from the latched operation, held stable, for ALU_LATENCY+1 cycles, counted by an internal down-counter.
REQ-019 On the rising edge ending the final EXEC cycle the block SHALL capture alu_result into rsp_result and go to RESP.
REQ-020 Latency: acceptance edge at end of cycle T -> rspN_valid high from cycle T+ALU_LATENCY+2.
REQ-021 In RESP the block SHALL assert only the owner's rspN_valid, hold rsp_result stable, and stay until rspN_ready=1, then go to IDLE.
REQ-022 rsp_ready of the non-owner SHALL be ignored; rspN_ready while rspN_valid=0 SHALL have no effect.
REQ-023 No acceptance SHALL occur in the RESP->IDLE transition cycle; a new request is accepted at the earliest in the first IDLE cycle.
REQ-024 alu_* outputs SHALL hold their last driven value in IDLE and RESP.
REQ-025 The block SHALL not modify operands; ALU decoding is entirely the ALU's responsibility.

Reset
REQ-026 With rst_n=0 at a rising edge the block SHALL enter IDLE, set last_grant=1 (requester 0 wins first tie), and clear rsp_result, all alu_* outputs, the counter and owner to 0.
REQ-027 During and after reset, req0_ready/req1_ready (until IDLE grant), rsp0_valid, rsp1_valid SHALL be 0.
REQ-028 Reset in EXEC or RESP SHALL abandon the operation; no response SHALL be issued for it.

Verification
REQ-029 Reset: rst_n=0 two cycles -> all outputs 0; first cycle after release with only req1_valid=1 -> req1_ready=1.
REQ-030 Single addu: req0 a=0x80000005, b=0x0000000D, funct=100000, accepted at T, ALU_LATENCY=1 -> rsp0_valid at T+3, rsp_result=0x80000012, rsp1_valid=0.
REQ-031 Tie: both valid continuously, rsp_ready=1 -> grant order req0, req1, req0, req1; each result returned to its owner only.
REQ-032 Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp_result stable, both req readys 0, no acceptance.
REQ-033 Reset mid-EXEC: rst_n=0 one cycle -> IDLE next cycle, no rsp valid for the aborted operation, alu_* = 0.
REQ-034 ALU_LATENCY=3: acceptance at T -> alu_* stable T+1..T+4, rspN_valid at T+5.
